// File: rtl/counter_pkg.sv
// Shared types and constants for the pushbutton-driven 2-bit counter.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } debounce_state_t;

  localparam int                 COUNT_W   = 2;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 2'd3;

endpackage

// File: rtl/debounce_fsm.sv
// Two-FF synchronizer plus press/release debounce FSM; emits a single-cycle
// press pulse per accepted press.
module debounce_fsm
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            sync_meta;
  logic            sync_x;
  debounce_state_t state;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here, synchronizer flops included, is cleared by the
  // synchronous reset so a mid-debounce reset can never leak a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_x    <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so sync_x sees last cycle's sync_meta.
      sync_meta <= btn;
      sync_x    <= sync_meta;
      press     <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (sync_x) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync_x) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync_x) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high returns to HELD silently: no second pulse.
          if (sync_x) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_counter_2bit.sv
// Modulo-4 up/down counter stepped by debounced inc/dec buttons; feeds the
// seven-segment decoder bcd input.
module button_counter_2bit
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_inc,
  input  logic               btn_dec,
  input  logic               en,
  output logic [COUNT_W-1:0] count,
  output logic               wrap
);

  logic press_inc;
  logic press_dec;

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_inc),
    .press (press_inc)
  );

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_dec),
    .press (press_dec)
  );

  // Simultaneous pulses cancel; pulses while disabled are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (en && (press_inc != press_dec)) begin
        if (press_inc) begin
          count <= count + 2'd1;
          wrap  <= (count == COUNT_MAX);
        end else begin
          count <= count - 2'd1;
          wrap  <= (count == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_button_counter_2bit.sv
// Directed plus randomized bench for button_counter_2bit against a
// run-length reference model of the debounce and counting rules.
module tb_button_counter_2bit;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       en = 1'b1;
  logic [1:0] count;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  button_counter_2bit #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .en      (en),
    .count   (count),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples reach the debouncer two edges late; the
  // accepted level flips after D+1 consecutive samples of the other level,
  // and a flip to 1 is a press that moves the count on the following edge.
  int m_count;
  int m_wrap;
  int m_press [2];
  int m_level [2];
  int m_run   [2];
  int m_hist1 [2];
  int m_hist2 [2];

  task automatic model_reset();
    m_count = 0;
    m_wrap  = 0;
    for (int b = 0; b < 2; b++) begin
      m_press[b] = 0; m_level[b] = 0; m_run[b] = 0;
      m_hist1[b] = 0; m_hist2[b] = 0;
    end
  endtask

  task automatic model_edge(input bit r, input bit i, input bit d, input bit e);
    int raw [2];
    int s;
    raw[0] = int'(i);
    raw[1] = int'(d);
    if (r) begin
      model_reset();
    end else begin
      m_wrap = 0;
      if (e && (m_press[0] + m_press[1] == 1)) begin
        if (m_press[0] == 1) begin
          m_wrap  = (m_count == 3) ? 1 : 0;
          m_count = (m_count + 1) % 4;
        end else begin
          m_wrap  = (m_count == 0) ? 1 : 0;
          m_count = (m_count + 3) % 4;
        end
      end
      for (int b = 0; b < 2; b++) begin
        s          = m_hist2[b];
        m_hist2[b] = m_hist1[b];
        m_hist1[b] = raw[b];
        m_press[b] = 0;
        if (s != m_level[b]) begin
          m_run[b]++;
          if (m_run[b] == D + 1) begin
            m_level[b] = s;
            m_run[b]   = 0;
            m_press[b] = s;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare 1 ns later.
  task automatic step(input bit r, input bit i, input bit d, input bit e);
    rst = r; btn_inc = i; btn_dec = d; en = e;
    @(posedge clk);
    model_edge(r, i, d, e);
    #1;
    check("count", int'(count), m_count);
    check("wrap", int'(wrap), m_wrap);
  endtask

  task automatic press(input bit i, input bit d, input bit e, input int hold, input int low);
    for (int k = 0; k < hold; k++) step(1'b0, i, d, e);
    for (int k = 0; k < low; k++) step(1'b0, 1'b0, 1'b0, e);
  endtask

  initial begin
    bit bounce_on  [9] = '{1, 1, 1, 0, 1, 1, 0, 1, 0};
    bit bounce_off [6] = '{0, 1, 0, 0, 0, 0};
    int wraps;
    int hold_i, hold_d, en_hold;
    bit lvl_i, lvl_d, en_r;

    model_reset();

    // Reset with buttons toggling.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("reset_count", int'(count), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Clean press: count becomes 1 exactly at edge 7.
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (k == 6) check("latency_before", int'(count), 0);
      if (k == 7) check("latency_after", int'(count), 1);
    end
    press(1'b0, 1'b0, 1'b1, 0, 12);
    check("clean_press", int'(count), 1);

    // Bouncy press and bouncy release: one step.
    foreach (bounce_on[k]) step(1'b0, bounce_on[k], 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b1, 20, 0);
    foreach (bounce_off[k]) step(1'b0, bounce_off[k], 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1, 0, 12);
    check("bounce_press", int'(count), 2);

    // 2 -> 3 (no wrap), 3 -> 0 (wrap), 0 -> 3 (wrap).
    press(1'b1, 1'b0, 1'b1, 10, 12);
    check("inc_to_3", int'(count), 3);
    wraps = 0;
    for (int k = 0; k < 22; k++) begin
      step(1'b0, k < 10, 1'b0, 1'b1);
      wraps += int'(wrap);
    end
    check("wrap_inc_pulses", wraps, 1);
    check("wrap_inc_count", int'(count), 0);
    press(1'b0, 1'b1, 1'b1, 10, 12);
    check("wrap_dec_count", int'(count), 3);
    press(1'b0, 1'b1, 1'b1, 10, 12);
    check("dec_to_2", int'(count), 2);

    // Simultaneous press cancels.
    press(1'b1, 1'b1, 1'b1, 10, 12);
    check("simultaneous", int'(count), 2);

    // Disabled press is dropped, not deferred.
    press(1'b1, 1'b0, 1'b0, 10, 0);
    press(1'b0, 1'b0, 1'b1, 0, 12);
    check("enable_drop", int'(count), 2);

    // Reset mid-press with button held: re-debounced, counts once.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("midpress_reset", int'(count), 0);
    press(1'b1, 1'b0, 1'b1, 15, 12);
    check("after_reset_press", int'(count), 1);

    // Randomized phase: held levels of random length make both clean
    // presses and bounce; en and rst change occasionally.
    lvl_i = 0; lvl_d = 0; en_r = 1;
    hold_i = 1; hold_d = 1; en_hold = 50;
    for (int c = 0; c < 4000; c++) begin
      if (--hold_i == 0) begin
        lvl_i = ~lvl_i; hold_i = int'($urandom_range(1, 25));
      end
      if (--hold_d == 0) begin
        lvl_d = ~lvl_d; hold_d = int'($urandom_range(1, 25));
      end
      if (--en_hold == 0) begin
        en_r = ($urandom_range(0, 3) != 0); en_hold = int'($urandom_range(5, 80));
      end
      step($urandom_range(0, 299) == 0, lvl_i, lvl_d, en_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
